// File: rtl/hex_line_pkg.sv
// Shared definitions for the hex line parser.
//   ASCII constants for the line syntax and the acknowledgement bytes,
//   the parser state encoding and the byte classification enum.
package hex_line_pkg;

    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_SP  = 8'h20;
    localparam logic [7:0] CHR_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] CHR_NAK = 8'h3F;  // '?'

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ERROR
    } state_t;

    typedef enum logic [2:0] {
        HEX,
        TERM,
        BS,
        SP,
        OTHER
    } byte_class_t;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII byte classifier.
//   byte_in : received byte
//   nibble  : hex value of byte_in (0 when byte_in is not a hex digit)
//   cls     : byte class (HEX, TERM, BS, SP, OTHER)
module hex_ascii_decode
    import hex_line_pkg::*;
(
    input  logic [7:0]  byte_in,
    output logic [3:0]  nibble,
    output byte_class_t cls
);

    always_comb begin
        nibble = 4'd0;
        cls    = OTHER;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            nibble = byte_in[3:0];
            cls    = HEX;
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps A..F onto 10..15
            nibble = byte_in[3:0] + 4'd9;
            cls    = HEX;
        end else if (byte_in == CHR_CR || byte_in == CHR_LF) begin
            cls = TERM;
        end else if (byte_in == CHR_BS) begin
            cls = BS;
        end else if (byte_in == CHR_SP) begin
            cls = SP;
        end
    end

endmodule

// File: rtl/hex_line_parser.sv
// Hex line parser: accumulates ASCII hex digits, commits the value on CR/LF
// with a one-cycle OUT_NEW strobe and returns 'K' (commit) or '?' (discarded
// line) through a START/BUSY handshake with a one-deep pending slot.
//   CLK, RST_N        : clock, async active-low reset
//   IN_DATA, IN_VALID : received byte and its strobe
//   OUT_DATA, OUT_NEW : last committed value and commit strobe
//   ERR               : high while the current line is being discarded
//   TX_DATA, TX_START : acknowledgement byte and send strobe
//   TX_BUSY           : sender busy
//
// state | meaning
// IDLE  | no digits collected for the current line
// ACCUM | 1..DIGITS digits held in acc
// ERROR | overflow or illegal byte seen, discarding until terminator
module hex_line_parser
    import hex_line_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic [4*DIGITS-1:0]   OUT_DATA,
    output logic                  OUT_NEW,
    output logic                  ERR,
    output logic [7:0]            TX_DATA,
    output logic                  TX_START,
    input  logic                  TX_BUSY
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_new_q, out_new_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            pend_valid_q, pend_valid_d;
    logic [7:0]      pend_byte_q, pend_byte_d;
    logic            holdoff_q, holdoff_d;

    logic [3:0]      nibble;
    byte_class_t     cls;
    logic            rsp_valid;
    logic [7:0]      rsp_byte;
    logic            can_send;

    hex_ascii_decode u_decode (
        .byte_in (IN_DATA),
        .nibble  (nibble),
        .cls     (cls)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_new_d  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_byte   = CHR_ACK;
        if (IN_VALID) begin
            case (state_q)
                IDLE: begin
                    if (cls == HEX) begin
                        acc_d   = {{(W-4){1'b0}}, nibble};
                        cnt_d   = CW'(1);
                        state_d = ACCUM;
                    end else if (cls == OTHER) begin
                        state_d = ERROR;
                    end
                end
                ACCUM: begin
                    case (cls)
                        HEX: begin
                            if (cnt_q == CNT_MAX) begin
                                state_d = ERROR;
                            end else begin
                                acc_d = {acc_q[W-5:0], nibble};
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        BS: begin
                            acc_d = {4'd0, acc_q[W-1:4]};
                            cnt_d = cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) state_d = IDLE;
                        end
                        TERM: begin
                            out_data_d = acc_q;
                            out_new_d  = 1'b1;
                            rsp_valid  = 1'b1;
                            rsp_byte   = CHR_ACK;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end
                        OTHER:   state_d = ERROR;
                        default: ;
                    endcase
                end
                ERROR: begin
                    if (cls == TERM) begin
                        rsp_valid = 1'b1;
                        rsp_byte  = CHR_NAK;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pending byte always goes out before a fresh one; a fresh byte that
    // cannot go out replaces whatever the slot holds.
    always_comb begin
        can_send     = !TX_BUSY && !holdoff_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        if (can_send && pend_valid_q) begin
            tx_start_d   = 1'b1;
            tx_data_d    = pend_byte_q;
            pend_valid_d = rsp_valid;
            if (rsp_valid) pend_byte_d = rsp_byte;
        end else if (can_send && rsp_valid) begin
            tx_start_d = 1'b1;
            tx_data_d  = rsp_byte;
        end else if (rsp_valid) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = rsp_byte;
        end
        // Sender raises BUSY one cycle after START, so skip that cycle.
        holdoff_d = tx_start_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_new_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            holdoff_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_new_q    <= out_new_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            holdoff_q    <= holdoff_d;
        end
    end

    assign OUT_DATA = out_data_q;
    assign OUT_NEW  = out_new_q;
    assign ERR      = (state_q == ERROR);
    assign TX_DATA  = tx_data_q;
    assign TX_START = tx_start_q;

endmodule

// File: tb/tb_hex_line_parser.sv
module tb_hex_line_parser;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [7:0]    IN_DATA = 8'h00;
    logic          IN_VALID = 1'b0;
    logic [W-1:0]  OUT_DATA;
    logic          OUT_NEW;
    logic          ERR;
    logic [7:0]    TX_DATA;
    logic          TX_START;
    logic          TX_BUSY = 1'b0;

    hex_line_parser #(.DIGITS(DIGITS)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .OUT_DATA (OUT_DATA),
        .OUT_NEW  (OUT_NEW),
        .ERR      (ERR),
        .TX_DATA  (TX_DATA),
        .TX_START (TX_START),
        .TX_BUSY  (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model: digits of the current line, error flag, scoreboards
    int            m_digits[$];
    bit            m_err = 1'b0;
    logic [W-1:0]  exp_out = '0;
    logic          exp_err = 1'b0;
    logic [7:0]    exp_txd = 8'h00;
    logic [W-1:0]  exp_commit[$];
    logic [7:0]    exp_tx[$];
    logic          prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] b);
        bit is_dec, is_up, is_lo, is_term;
        int nib;
        int v;
        is_dec  = (b >= "0" && b <= "9");
        is_up   = (b >= "A" && b <= "F");
        is_lo   = (b >= "a" && b <= "f");
        is_term = (b == 8'd13 || b == 8'd10);
        nib = is_dec ? int'(b) - int'("0") :
              is_up  ? int'(b) - int'("A") + 10 :
                       int'(b) - int'("a") + 10;
        if (m_err) begin
            if (is_term) begin
                exp_tx.push_back(8'h3F);
                m_err = 1'b0;
                m_digits.delete();
            end
        end else if (is_dec || is_up || is_lo) begin
            if (m_digits.size() == DIGITS) m_err = 1'b1;
            else m_digits.push_back(nib);
        end else if (is_term) begin
            if (m_digits.size() > 0) begin
                v = 0;
                foreach (m_digits[i]) v = v * 16 + m_digits[i];
                exp_out = v[W-1:0];
                exp_commit.push_back(v[W-1:0]);
                exp_tx.push_back(8'h4B);
                m_digits.delete();
            end
        end else if (b == 8'd8) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (b != 8'd32) begin
            m_err = 1'b1;
        end
        exp_err = m_err;
    endtask

    // driver actions happen 1 time unit after the rising edge
    task automatic send_byte(input logic [7:0] b);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        model_step(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // monitor: compares everything the DUT presents against the model
    always @(negedge CLK) begin
        chk("err", ERR, exp_err);
        chk("out_data", OUT_DATA, exp_out);
        if (OUT_NEW) begin
            if (exp_commit.size() == 0) begin
                chk("unexpected_out_new", 1, 0);
            end else begin
                chk("commit_value", OUT_DATA, exp_commit.pop_front());
            end
        end
        if (TX_START) begin
            chk("tx_start_back_to_back", prev_start, 0);
            if (exp_tx.size() == 0) begin
                chk("unexpected_tx_start", 1, 0);
            end else begin
                exp_txd = exp_tx.pop_front();
            end
        end
        chk("tx_data", TX_DATA, exp_txd);
        prev_start = TX_START;
    end

    function automatic logic [7:0] rand_char();
        string hexs;
        int    sel;
        hexs = "0123456789abcdefABCDEF";
        sel  = $urandom_range(0, 19);
        if (sel < 12) return hexs[$urandom_range(0, 21)];
        if (sel < 14) return 8'd8;
        if (sel == 14) return 8'd32;
        if (sel == 15) return "g";
        if (sel == 16) return "Z";
        if (sel == 17) return 8'd13;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_out_data", OUT_DATA, 0);
        chk("reset_out_new", OUT_NEW, 0);
        chk("reset_err", ERR, 0);
        chk("reset_tx_data", TX_DATA, 0);
        chk("reset_tx_start", TX_START, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(2);

        send_str("1A2f\015");
        idle(4);
        chk("dir_1A2F", OUT_DATA, 16'h1A2F);
        send_str("12\015\012");
        idle(4);
        chk("dir_12_crlf", OUT_DATA, 16'h0012);
        send_str("123\0104\015");
        idle(4);
        chk("dir_bs", OUT_DATA, 16'h0124);
        send_str("1\010\015");
        idle(4);
        chk("dir_bs_empty", OUT_DATA, 16'h0124);
        send_str("12345");
        idle(1);
        chk("dir_overflow_err", ERR, 1);
        send_str("\015");
        idle(4);
        chk("dir_overflow_keep", OUT_DATA, 16'h0124);
        send_str("1g");
        idle(1);
        chk("dir_illegal_err", ERR, 1);
        send_str("\015");
        idle(4);

        // backpressure: two acks while busy, only the newest survives
        TX_BUSY = 1'b1;
        send_str("1\0152\015");
        idle(3);
        chk("bp_two_acks_queued", exp_tx.size(), 2);
        void'(exp_tx.pop_front());
        TX_BUSY = 1'b0;
        idle(6);
        chk("bp_one_ack_sent", exp_tx.size(), 0);
        chk("bp_out_data", OUT_DATA, 16'h0002);

        // reset in the middle of a line
        send_str("AB");
        RST_N = 1'b0;
        m_digits.delete();
        m_err      = 1'b0;
        exp_err    = 1'b0;
        exp_out    = '0;
        exp_txd    = 8'h00;
        exp_commit.delete();
        exp_tx.delete();
        @(negedge CLK);
        chk("midrst_out_data", OUT_DATA, 0);
        chk("midrst_out_new", OUT_NEW, 0);
        chk("midrst_err", ERR, 0);
        chk("midrst_tx_data", TX_DATA, 0);
        chk("midrst_tx_start", TX_START, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(1);
        send_str("C\015");
        idle(4);
        chk("after_rst_C", OUT_DATA, 16'h000C);

        // randomized lines with random gaps
        for (int n = 0; n < 300; n++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                send_byte(rand_char());
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            send_byte(($urandom_range(0, 1) == 0) ? 8'd13 : 8'd10);
            if ($urandom_range(0, 3) == 0) send_byte(8'd10);
            idle($urandom_range(0, 2));
        end

        idle(10);
        chk("drain_commits", exp_commit.size(), 0);
        chk("drain_tx", exp_tx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
